// File: rtl/bcd_counter_2d.sv
// Two-digit BCD counter with a tick prescaler, a synchronous load and registered outputs.
// Optional macro BCD_DOWN_EN enables down counting through the `up` port; without it the counter is up-only.
module bcd_counter_2d #(
    parameter int unsigned DIV = 50_000_000,
    parameter int unsigned MOD = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       tick,
    output logic       carry,
    output logic       load_err
);

    localparam logic [31:0] PCNT_LAST = 32'(DIV - 1);
    localparam logic [3:0]  MAX_TENS  = 4'((MOD - 1) / 10);
    localparam logic [3:0]  MAX_UNITS = 4'((MOD - 1) % 10);
    localparam logic [7:0]  MOD_B     = 8'(MOD);

    logic [31:0] pcnt;
    logic        wrap;
    logic [7:0]  load_val;
    logic        load_ok;
    logic        step_up;
    logic [3:0]  nxt_tens;
    logic [3:0]  nxt_units;
    logic        nxt_carry;

    assign wrap     = (pcnt == PCNT_LAST);
    assign load_val = 8'(load_tens) * 8'd10 + 8'(load_units);
    assign load_ok  = (load_tens <= 4'd9) && (load_units <= 4'd9) && (load_val < MOD_B);

`ifdef BCD_DOWN_EN
    assign step_up = up;
`else
    // Up-only build: the direction input is kept on the port but has no load.
    logic unused_up;
    assign unused_up = up;
    assign step_up   = 1'b1;
`endif

    // Digits one step ahead of the current count, in the selected direction.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        nxt_tens  = tens;
        nxt_units = units;
        nxt_carry = 1'b0;
        if (step_up) begin
            if (tens == MAX_TENS && units == MAX_UNITS) begin
                nxt_tens  = 4'd0;
                nxt_units = 4'd0;
                nxt_carry = 1'b1;
            end else if (units == 4'd9) begin
                nxt_units = 4'd0;
                nxt_tens  = tens + 4'd1;
            end else begin
                nxt_units = units + 4'd1;
            end
        end
`ifdef BCD_DOWN_EN
        else begin
            if (tens == 4'd0 && units == 4'd0) begin
                nxt_tens  = MAX_TENS;
                nxt_units = MAX_UNITS;
                nxt_carry = 1'b1;
            end else if (units == 4'd0) begin
                nxt_units = 4'd9;
                nxt_tens  = tens - 4'd1;
            end else begin
                nxt_units = units - 4'd1;
            end
        end
`endif
    end

    // Reset beats load, load beats a prescaler step; pulses default low every cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            pcnt     <= '0;
            tens     <= '0;
            units    <= '0;
            tick     <= 1'b0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= 1'b0;
            carry    <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                pcnt <= '0;
                if (load_ok) begin
                    tens  <= load_tens;
                    units <= load_units;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (wrap) begin
                    pcnt  <= '0;
                    tens  <= nxt_tens;
                    units <= nxt_units;
                    tick  <= 1'b1;
                    carry <= nxt_carry;
                end else begin
                    pcnt <= pcnt + 32'd1;
                end
            end
        end
    end

endmodule
